// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them into the
// instruction ROM, and holds the core in reset until the image is in. Optional: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [15:0]           word_count_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  cpu_reset_o
);

  localparam logic [16:0] DEPTH_L = 17'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           index_q, index_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic accept;
  assign accept = byte_valid_i && ready_q;

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    cpu_rst_d = cpu_rst_q;
    count_d   = count_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          count_d = word_count_i;
          if (word_count_i == '0) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            cpu_rst_d = 1'b0;
          end else if ({1'b0, word_count_i} > DEPTH_L) begin
            state_d   = S_IDLE;
            error_d   = 1'b1;
            busy_d    = 1'b0;
            cpu_rst_d = 1'b1;
          end else begin
            state_d   = S_COLLECT;
            index_d   = '0;
            cnt_d     = '0;
            ready_d   = 1'b1;
            busy_d    = 1'b1;
            cpu_rst_d = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_d     = '0;
`endif
          end
        end
      end

      S_COLLECT: begin
        if (accept) begin
          word_d[{cnt_q, 3'b000} +: 8] = byte_i;
          cnt_d = 2'(cnt_q + 2'd1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d = 8'(sum_q + byte_i);
`endif
          // Address/data are registered here so the strobe lands in the WRITE cycle.
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
            ready_d = 1'b0;
            we_d    = 1'b1;
            addr_d  = BASE_ADDRESS + {14'b0, index_q, 2'b00};
            data_d  = word_d;
          end
        end
      end

      S_WRITE: begin
        index_d = 16'(index_q + 16'd1);
        if (index_d == count_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d   = S_CHECK;
          ready_d   = 1'b1;
`else
          state_d   = S_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cpu_rst_d = 1'b0;
`endif
        end else begin
          state_d = S_COLLECT;
          ready_d = 1'b1;
        end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          ready_d = 1'b0;
          busy_d  = 1'b0;
          if (8'(sum_q + byte_i) == 8'h00) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d   = S_IDLE;
            error_d   = 1'b1;
            cpu_rst_d = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d   = S_IDLE;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
        cpu_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= BASE_ADDRESS;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      count_q   <= '0;
      index_q   <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cpu_rst_q <= cpu_rst_d;
      count_q   <= count_d;
      index_q   <= index_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign byte_ready_o  = ready_q;
  assign mem_we_o      = we_q;
  assign mem_address_o = addr_q;
  assign mem_data_o    = data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign cpu_reset_o   = cpu_rst_q;

endmodule
